// File: rtl/dff_stream_pkg.sv
// dff_stream_pkg: shared state type and default framing constants for the deframer
package dff_stream_pkg;
    typedef enum logic {HUNT, COLLECT} deframer_state_t;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_SYNC_LEN = 4;
    localparam logic [DEF_SYNC_LEN-1:0] DEF_SYNC_PATTERN = 4'b1011;
endpackage

// File: rtl/dff_sync_detect.sv
// dff_sync_detect: hunt shift register with a match flag computed on the incoming bit
module dff_sync_detect
    import dff_stream_pkg::*;
#(
    parameter int SYNC_LEN = DEF_SYNC_LEN,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = DEF_SYNC_PATTERN
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    input  logic bit_in,
    output logic match
);
    logic [SYNC_LEN-1:0] hunt_sr;
    logic [SYNC_LEN-1:0] shifted;
    assign shifted = {hunt_sr[SYNC_LEN-2:0], bit_in};
    assign match = en && (shifted == SYNC_PATTERN);
    always_ff @(posedge clk) begin
        if (rst || clear) hunt_sr <= '0;
        else if (en) hunt_sr <= shifted;
    end
endmodule

// File: rtl/dff_stream_deframer.sv
// dff_stream_deframer: sync-hunting serial-to-parallel deframer with one-entry valid/ready output
module dff_stream_deframer
    import dff_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SYNC_LEN = DEF_SYNC_LEN,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = DEF_SYNC_PATTERN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_en,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             sync_lock,
    output logic             overrun
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    deframer_state_t state, state_next;
    logic [WIDTH-1:0] data_sr;
    logic [WIDTH-1:0] word_next;
    logic [CW-1:0] bit_cnt;
    logic match, take, done;
    assign take = bit_en && (state == COLLECT);
    assign done = take && (bit_cnt == LAST);
    assign word_next = {data_sr[WIDTH-2:0], bit_in};
    assign sync_lock = (state == COLLECT);
    dff_sync_detect #(.SYNC_LEN(SYNC_LEN), .SYNC_PATTERN(SYNC_PATTERN)) u_sync (
        .clk(clk),
        .rst(rst),
        .en(bit_en && (state == HUNT)),
        .clear(done),
        .bit_in(bit_in),
        .match(match)
    );
    always_comb begin
        state_next = state;
        state_next = match ? COLLECT : done ? HUNT : state;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= HUNT;
        else state <= state_next;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            data_sr    <= '0;
            bit_cnt    <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (match) bit_cnt <= '0;
            if (take) begin
                data_sr <= word_next;
                bit_cnt <= done ? '0 : bit_cnt + 1'b1;
            end
            // a completing frame may reuse the slot being popped in the same cycle
            if (done && (!word_valid || word_ready)) begin
                word_out   <= word_next;
                word_valid <= 1'b1;
            end else if (done) begin
                overrun <= 1'b1;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dff_stream_deframer.sv
// tb_dff_stream_deframer: vector table, directed corner sequences and a randomized model comparison
module tb_dff_stream_deframer;
    logic clk = 1'b0;
    logic rst, bit_in, bit_en, word_ready;
    logic [7:0] word_out;
    logic word_valid, sync_lock, overrun;
    int checks = 0;
    int errors = 0;
    // reference: window of recent hunt bits, collected data bits, single holding slot
    logic m_lock, m_valid, m_ovr;
    logic [3:0] m_win;
    logic [7:0] m_data, m_word;
    int m_n;

    dff_stream_deframer dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en),
        .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .sync_lock(sync_lock), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", n, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic b, input logic e, input logic rd);
        logic push;
        push = 1'b0;
        if (r) begin
            m_lock = 0; m_valid = 0; m_ovr = 0; m_win = 0; m_data = 0; m_word = 0; m_n = 0;
        end else begin
            if (e && !m_lock) begin
                m_win = {m_win[2:0], b};
                if (m_win == 4'b1011) begin m_lock = 1; m_n = 0; end
            end else if (e) begin
                m_data = {m_data[6:0], b};
                m_n++;
                if (m_n == 8) begin m_lock = 0; m_win = 0; push = 1; end
            end
            if (push && (!m_valid || rd)) begin m_word = m_data; m_valid = 1; end
            else if (push) m_ovr = 1;
            else if (m_valid && rd) m_valid = 0;
        end
    endtask

    task automatic step(input logic r, input logic b, input logic e, input logic rd);
        rst = r; bit_in = b; bit_en = e; word_ready = rd;
        @(posedge clk);
        model_edge(r, b, e, rd);
        #1;
        chk("word_valid", word_valid, m_valid);
        chk("sync_lock", sync_lock, m_lock);
        chk("overrun", overrun, m_ovr);
        if (m_valid) chk("word_out", word_out, m_word);
    endtask

    task automatic send_frame(input logic [7:0] w, input logic rd, input logic rd_last);
        logic [3:0] s;
        s = 4'b1011;
        for (int i = 3; i >= 0; i--) step(0, s[i], 1, rd);
        for (int i = 7; i >= 0; i--) step(0, w[i], 1, (i == 0) ? rd_last : rd);
    endtask

    typedef struct {
        logic b;
        logic [7:0] w;
        logic v;
        logic l;
    } vec_t;
    vec_t tbl[13];

    initial begin
        logic [7:0] a5;
        logic [3:0] win;
        logic nb;
        a5 = 8'hA5;
        tbl[0] = '{1, 8'h00, 0, 0};
        tbl[1] = '{0, 8'h00, 0, 0};
        tbl[2] = '{1, 8'h00, 0, 0};
        tbl[3] = '{1, 8'h00, 0, 1};
        for (int i = 0; i < 8; i++) tbl[4+i] = '{a5[7-i], 8'h00, 0, (i != 7)};
        tbl[11].w = 8'hA5; tbl[11].v = 1;
        tbl[12] = '{0, 8'hA5, 0, 0};

        step(1, 0, 0, 0);
        chk("reset_word", word_out, 0);
        chk("reset_valid", word_valid, 0);
        chk("reset_lock", sync_lock, 0);
        chk("reset_ovr", overrun, 0);

        for (int i = 0; i < 13; i++) begin
            step(0, tbl[i].b, 1, 1);
            chk("tbl_valid", word_valid, tbl[i].v);
            chk("tbl_lock", sync_lock, tbl[i].l);
            chk("tbl_word", word_out, tbl[i].w);
            chk("tbl_ovr", overrun, 0);
        end

        step(1, 0, 0, 0);
        send_frame(8'hA5, 0, 0);
        send_frame(8'h3C, 0, 0);
        chk("bp_word", word_out, 8'hA5);
        chk("bp_valid", word_valid, 1);
        chk("bp_ovr", overrun, 1);
        step(0, 0, 0, 1);
        chk("bp_pop", word_valid, 0);
        chk("bp_ovr_sticky", overrun, 1);

        step(1, 0, 0, 0);
        send_frame(8'hA5, 0, 0);
        send_frame(8'h3C, 0, 1);
        chk("pp_word", word_out, 8'h3C);
        chk("pp_valid", word_valid, 1);
        chk("pp_ovr", overrun, 0);

        step(1, 0, 0, 0);
        begin
            logic [11:0] f;
            f = {4'b1011, 8'hA5};
            for (int i = 11; i >= 0; i--) begin
                step(0, f[i], 1, 1);
                step(0, ~f[i], 0, 1);
                step(0, ~f[i], 0, 1);
            end
        end
        chk("gap_word", word_out, 8'hA5);

        step(1, 0, 0, 0);
        begin
            logic [5:0] p;
            p = 6'b101011;
            for (int i = 5; i >= 0; i--) begin
                step(0, p[i], 1, 0);
                chk("ovl_lock", sync_lock, i == 0);
            end
            for (int i = 7; i >= 0; i--) step(0, a5[i] ^ 1'b0 ? 1'b0 : 1'b0, 0, 0);
        end
        begin
            logic [7:0] d;
            d = 8'h3C;
            for (int i = 7; i >= 0; i--) step(0, d[i], 1, 0);
        end
        chk("ovl_word", word_out, 8'h3C);
        chk("ovl_valid", word_valid, 1);

        step(1, 0, 0, 1);
        win = 0;
        for (int i = 0; i < 200; i++) begin
            nb = 1'($urandom_range(0, 1));
            if ({win[2:0], nb} == 4'b1011) nb = 0;
            win = {win[2:0], nb};
            step(0, nb, 1, 1);
        end
        chk("noise_valid", word_valid, 0);

        step(1, 0, 0, 0);
        for (int i = 3; i >= 0; i--) step(0, i != 2, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0);
        step(1, 1, 1, 1);
        chk("mr_word", word_out, 0);
        chk("mr_valid", word_valid, 0);
        chk("mr_lock", sync_lock, 0);
        chk("mr_ovr", overrun, 0);
        send_frame(8'hFF, 0, 0);
        chk("mr_ff", word_out, 8'hFF);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
